// File: rtl/ntt_core_pkg.sv
// ntt_core_pkg: shared constants and elaboration/datapath helpers for the
// forward cyclic NTT core.
//   - NTT_* defaults: coefficient width, point count, modulus, root of unity
//   - clog2, bitrev  : index arithmetic for the fixed butterfly wiring
//   - pow_mod        : twiddle constants W^k mod Q, evaluated at elaboration
//   - mod_add/sub/mul: modular arithmetic on operands already in [0, Q-1]
package ntt_core_pkg;

  localparam int NTT_N = 9;
  localparam int NTT_D = 8;
  localparam int NTT_Q = 257;
  localparam int NTT_W = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int bitrev(input int idx, input int bits);
    int r;
    r = 0;
    for (int k = 0; k < bits; k++) r = (r << 1) | ((idx >> k) & 1);
    return r;
  endfunction

  function automatic int mod_add(input int x, input int y, input int q);
    int s;
    s = x + y;
    return (s >= q) ? s - q : s;
  endfunction

  function automatic int mod_sub(input int x, input int y, input int q);
    return (x >= y) ? x - y : x - y + q;
  endfunction

  function automatic int mod_mul(input int x, input int y, input int q);
    longint p;
    p = longint'(x) * longint'(y);
    return int'(p % longint'(q));
  endfunction

  function automatic int pow_mod(input int b, input int e, input int q);
    int acc;
    acc = 1 % q;
    for (int k = 0; k < e; k++) acc = mod_mul(acc, b, q);
    return acc;
  endfunction

endpackage

// File: rtl/ntt_core_butterfly.sv
// ntt_butterfly: combinational radix-2 Cooley-Tukey butterfly over Z_Q.
//   x, y : input operands in [0, Q-1]
//   w    : twiddle in [0, Q-1]
//   xo   : (x + w*y) mod Q
//   yo   : (x - w*y) mod Q
module ntt_butterfly
  import ntt_core_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int Q = NTT_Q
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] w,
  output logic [N-1:0] xo,
  output logic [N-1:0] yo
);

  logic [2*N-1:0] prod;
  logic [N-1:0]   t;

  // Full 2N-bit product, then a single reduction into [0, Q-1].
  assign prod = (2*N)'(w) * (2*N)'(y);
  assign t    = N'(prod % (2*N)'(Q));

  assign xo = N'(mod_add(int'(x), int'(t), Q));
  assign yo = N'(mod_sub(int'(x), int'(t), Q));

endmodule

// File: rtl/ntt_core.sv
// ntt_core: fully pipelined forward cyclic NTT, A_k = sum_j a_j*W^(j*k) mod Q.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset, clears valids and data
//   in_valid  : a carries a vector this cycle
//   a         : D packed N-bit coefficients, element i at [N*i +: N]
//   out_valid : an carries a new result this cycle
//   an        : D packed N-bit results, natural order, held between results
// Latency is log2(D)+1 cycles from the sampling edge; one vector per cycle.
module ntt_core
  import ntt_core_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int D = NTT_D,
  parameter int Q = NTT_Q,
  parameter int W = NTT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [D*N-1:0] a,
  output logic           out_valid,
  output logic [D*N-1:0] an
);

  localparam int STAGES = clog2(D);

  logic [N-1:0]    dat_p  [0:STAGES][0:D-1];
  logic [STAGES:0] vld_p;
  logic [N-1:0]    bf_in  [1:STAGES][0:D-1];
  logic [N-1:0]    bf_out [1:STAGES][0:D-1];

  // Inputs are at most 2^N-1 < 2Q, so one conditional subtract fully reduces.
  function automatic logic [N-1:0] cond_sub_q(input logic [N-1:0] v);
    return (v >= N'(Q)) ? v - N'(Q) : v;
  endfunction

  // Decimation-in-time: the first layer reads stage 0 in bit-reversed order,
  // so the last layer produces results in natural order.
  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    localparam int HALF = 1 << (s - 1);

    for (genvar i = 0; i < D; i++) begin : g_in
      if (s == 1) begin : g_brv
        assign bf_in[s][i] = dat_p[0][bitrev(i, STAGES)];
      end else begin : g_nat
        assign bf_in[s][i] = dat_p[s-1][i];
      end
    end

    for (genvar b = 0; b < D / 2; b++) begin : g_bf
      localparam int J  = b % HALF;
      localparam int I0 = (b / HALF) * 2 * HALF + J;
      localparam int I1 = I0 + HALF;
      localparam logic [N-1:0] TW = N'(pow_mod(W, J * (D >> s), Q));

      ntt_butterfly #(
        .N(N),
        .Q(Q)
      ) u_bf (
        .x (bf_in[s][I0]),
        .y (bf_in[s][I1]),
        .w (TW),
        .xo(bf_out[s][I0]),
        .yo(bf_out[s][I1])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
      an        <= '0;
      for (int s = 0; s <= STAGES; s++) begin
        for (int i = 0; i < D; i++) dat_p[s][i] <= '0;
      end
    end else begin
      // Stage 0: input register with reduction into [0, Q-1]
      vld_p[0] <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < D; i++) dat_p[0][i] <= cond_sub_q(a[N*i +: N]);
      end
      // Stages 1..STAGES: one butterfly layer each
      for (int s = 1; s <= STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
        for (int i = 0; i < D; i++) dat_p[s][i] <= bf_out[s][i];
      end
      // Output register: holds the last valid result through bubbles
      out_valid <= vld_p[STAGES];
      if (vld_p[STAGES]) begin
        for (int i = 0; i < D; i++) an[N*i +: N] <= dat_p[STAGES][i];
      end
    end
  end

endmodule

// File: tb/tb_ntt_core.sv
// tb_ntt_core: directed bench for ntt_core (N=9, D=8, Q=257, W=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ntt_core;

  localparam int N = 9;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [D*N-1:0] a;
  logic           out_valid;
  logic [D*N-1:0] an;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ntt_core dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .out_valid(out_valid),
    .an       (an)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [D*N-1:0] pack(input int v[D]);
    logic [D*N-1:0] r;
    for (int k = 0; k < D; k++) r[N*k +: N] = N'(v[k]);
    return r;
  endfunction

  task automatic chk_an(input string tag, input int e[D]);
    for (int k = 0; k < D; k++)
      chk($sformatf("%s an[%0d]", tag, k), 32'(an[N*k +: N]), 32'(e[k]));
  endtask

  task automatic drive(input logic v, input int x[D]);
    @(negedge clk);
    in_valid = v;
    a        = pack(x);
  endtask

  // Single vector: out_valid must rise exactly 4 edges after the sampling edge,
  // last one cycle, and an must hold afterwards.
  task automatic run_one(input string tag, input int x[D], input int e[D]);
    int z[D];
    z = '{default: 0};
    drive(1'b1, x);
    drive(1'b0, z);
    chk({tag, " lat1"}, 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, " lat3"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk_an(tag, e);
    @(negedge clk);
    chk({tag, " pulse"}, 32'(out_valid), 32'd0);
    chk_an({tag, " hold"}, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x[D], e[D], z[D];
    int v1[D], e1[D], v2[D], e2[D], v3[D], e3[D];
    z = '{default: 0};

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk_an("reset", z);
    @(negedge clk);
    rst = 1'b0;

    x = '{1, 1, 1, 1, 1, 1, 1, 1};   e = '{8, 0, 0, 0, 0, 0, 0, 0};
    run_one("ones", x, e);
    x = '{1, 0, 0, 0, 0, 0, 0, 0};   e = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_one("impulse", x, e);
    x = '{0, 1, 0, 0, 0, 0, 0, 0};   e = '{1, 4, 16, 64, 256, 253, 241, 193};
    run_one("a1", x, e);
    x = '{0, 0, 0, 0, 1, 0, 0, 0};   e = '{1, 256, 1, 256, 1, 256, 1, 256};
    run_one("a4", x, e);
    x = '{257, 257, 257, 257, 257, 257, 257, 257};  e = '{default: 0};
    run_one("all257", x, e);
    x = '{300, 0, 0, 0, 0, 0, 0, 0}; e = '{43, 43, 43, 43, 43, 43, 43, 43};
    run_one("a0_300", x, e);

    // Streaming with a bubble before the third vector.
    v1 = '{1, 1, 1, 1, 1, 1, 1, 1};  e1 = '{8, 0, 0, 0, 0, 0, 0, 0};
    v2 = '{0, 1, 0, 0, 0, 0, 0, 0};  e2 = '{1, 4, 16, 64, 256, 253, 241, 193};
    v3 = '{0, 0, 1, 0, 0, 0, 0, 0};  e3 = '{1, 16, 256, 241, 1, 16, 256, 241};
    drive(1'b1, v1);
    drive(1'b1, v2);
    drive(1'b0, z);
    drive(1'b1, v3);
    drive(1'b0, z);
    chk("stream pre", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("stream v1 valid", 32'(out_valid), 32'd1);
    chk_an("stream v1", e1);
    @(negedge clk);
    chk("stream v2 valid", 32'(out_valid), 32'd1);
    chk_an("stream v2", e2);
    @(negedge clk);
    chk("stream bubble", 32'(out_valid), 32'd0);
    chk_an("stream bubble hold", e2);
    @(negedge clk);
    chk("stream v3 valid", 32'(out_valid), 32'd1);
    chk_an("stream v3", e3);
    @(negedge clk);
    chk("stream end", 32'(out_valid), 32'd0);

    // Reset while the output is valid and further vectors are in flight.
    drive(1'b1, v1);
    drive(1'b1, v2);
    drive(1'b1, v3);
    drive(1'b1, v1);
    drive(1'b1, v2);
    drive(1'b0, z);
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    chk_an("pre-reset", e1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk_an("async reset", z);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset c%0d", c), 32'(out_valid), 32'd0);
    end
    chk_an("post-reset", z);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ntt_core.md
Name: ntt_core

Overview:
- Pipelined forward number-theoretic transform (cyclic NTT) over Z_Q of D coefficients, each N bits wide.
- Takes a packed coefficient vector and returns the packed transform A_k = sum_j a_j·W^(j·k) mod Q, both in natural order.
- Sits in the polynomial-arithmetic datapath as the transform front end feeding pointwise multiply.
- Fully pipelined: accepts one vector per clock.

Parameters:
- N, 9, coefficient bit width.
- D, 8, number of points; power of two, ≥2.
- Q, 257, prime modulus; requires Q < 2^N, 2^N−1 < 2Q, Q ≡ 1 mod D.
- W, 4, primitive D-th root of unity mod Q (4^4 = 256 ≡ −1 mod 257).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, a holds a vector to transform this cycle.
- a, input, D*N, input coefficients; element i at bits [N*(i+1)-1 : N*i].
- out_valid, output, 1, an holds a new result this cycle.
- an, output, D*N, transform result, same packing as a.

Behaviour:
- Reset (async, active-high): out_valid=0, an=0, all pipeline valid bits and data registers cleared immediately, independent of clk.
- No result issued from pre-reset inputs after rst deasserts.
- Stage 0 (input register): samples a when in_valid=1.
  - Each element ≥ Q is reduced by a single conditional subtract of Q; valid because 2^N−1 < 2Q.
- Stages 1..log2(D): one registered radix-2 butterfly layer each.
  - Butterfly: t = w·y mod Q (2N-bit product, reduced); x' = (x+t) mod Q; y' = (x−t) mod Q.
  - All results lie in [0, Q−1].
  - Bit-reversal permutation and twiddle selection are fixed wiring and constants; twiddles are W^k mod Q, computed at elaboration.
- Latency: out_valid rises exactly log2(D)+1 cycles after the clk edge that sampled in_valid=1 (4 cycles at D=8).
- Throughput: one vector per cycle, no stalls, no back-pressure. in_valid may be high on any number of consecutive cycles; outputs emerge in input order on consecutive cycles.
- A valid bit travels with each pipeline stage. Bubbles (in_valid=0) propagate as out_valid=0.
- an holds the last valid result until the next out_valid=1.
- an is registered; there is no combinational path from a to an.
- The transform is cyclic (no negacyclic pre-twist, no scaling by 1/D).

Decomposition:
- Shared package:
  - Q, W, N, D defaults.
  - clog2 constant function.
  - twiddle function pow_mod(W, k, Q).
  - mod_add / mod_sub / mod_mul helper functions.
  - bit-reverse index function.
- Sub-module ntt_butterfly (combinational, parameters N and Q):
  - inputs x, y, w; outputs x', y'.
  - Instantiated D/2 times per stage via generate.

Test Plan:
- All elements = 1, single in_valid pulse -> after 4 cycles out_valid=1 for one cycle, an[0]=8, an[1..7]=0; an then holds.
- Impulse a[0]=1, others 0 -> all an[k]=1.
- a[1]=1, others 0 -> an = 1,4,16,64,256,253,241,193 for k=0..7.
- Unreduced input: all elements 257 -> all an[k]=0; a[0]=300 with others 0 -> every an[k]=43.
- Streaming: vectors V1, V2, V3 on three consecutive cycles with a 1-cycle bubble before V3 -> results in order, out_valid pattern 1,1,0,1 starting 4 cycles after V1, each result matching its reference NTT.
- Reset mid-operation: assert rst while 3 vectors are in flight -> out_valid=0 and an=0 immediately, before the next clk edge; after release with in_valid=0, out_valid stays 0.
